// File: rtl/car_sensor_pkg.sv
// Shared constants for the car sensor emulator: FSM encoding, sensor codes, directions.
// phase_code maps the current phase and direction to the {sensorA,sensorB} pattern.
package car_sensor_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P1   = 3'd1;
  localparam logic [2:0] ST_P2   = 3'd2;
  localparam logic [2:0] ST_P3   = 3'd3;
  localparam logic [2:0] ST_P4   = 3'd4;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_A    = 2'b10;
  localparam logic [1:0] CODE_AB   = 2'b11;
  localparam logic [1:0] CODE_B    = 2'b01;

  localparam logic DIR_EXIT  = 1'b0;
  localparam logic DIR_ENTER = 1'b1;

  function automatic logic [1:0] phase_code(input logic [2:0] st, input logic dir);
    logic [1:0] code;
    code = CODE_NONE;
    case (st)
      ST_P1:   code = (dir == DIR_ENTER) ? CODE_A : CODE_B;
      ST_P2:   code = CODE_AB;
      ST_P3:   code = (dir == DIR_ENTER) ? CODE_B : CODE_A;
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times how long each sensor phase is held.
// Counts down to zero and then rests there; expire flags the final cycle of a phase.
module phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clk) begin
    if (res) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (value_q != '0) begin
      value_q <= value_q - WIDTH'(1);
    end
  end

  assign value  = value_q;
  assign expire = (value_q == '0);

endmodule

// File: rtl/car_sensor_emulator.sv
// Plays enter/exit commands as four-phase gate-sensor waveforms and tracks the
// lot occupancy a correct car-counting detector should report.
module car_sensor_emulator
  import car_sensor_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned COUNT_W = 14
) (
  input  logic               clk,
  input  logic               res,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [DWELL_W-1:0] cmd_dwell,
  output logic               sensorA,
  output logic               sensorB,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] exp_count
);

  logic [2:0]         state_q, state_d;
  logic               dir_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [COUNT_W-1:0] count_q;

  logic               accept;
  logic [DWELL_W-1:0] dwell_eff;
  logic               timer_load;
  logic [DWELL_W-1:0] timer_load_val;
  logic [DWELL_W-1:0] timer_value;
  logic               timer_expire;

  assign cmd_ready = (state_q == ST_IDLE) && !res;
  assign accept    = cmd_valid && cmd_ready;
  assign dwell_eff = (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;
  assign busy      = (state_q != ST_IDLE);

  // Reload on accept and on every phase change so each phase lasts exactly dwell cycles.
  assign timer_load     = accept || (busy && timer_expire);
  assign timer_load_val = accept ? (dwell_eff - DWELL_W'(1)) : (dwell_q - DWELL_W'(1));

  phase_timer #(
    .WIDTH(DWELL_W)
  ) u_phase_timer (
    .clk     (clk),
    .res     (res),
    .load    (timer_load),
    .load_val(timer_load_val),
    .value   (timer_value),
    .expire  (timer_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)       state_d = ST_P1;
      ST_P1:   if (timer_expire) state_d = ST_P2;
      ST_P2:   if (timer_expire) state_d = ST_P3;
      ST_P3:   if (timer_expire) state_d = ST_P4;
      ST_P4:   if (timer_expire) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_EXIT;
      dwell_q <= DWELL_W'(1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_q   <= cmd_dir;
        dwell_q <= dwell_eff;
      end
      // Count moves on the edge the sensors clear, when the detector counts too.
      if (state_q == ST_P3 && timer_expire) begin
        count_q <= (dir_q == DIR_ENTER) ? count_q + COUNT_W'(1) : count_q - COUNT_W'(1);
      end
    end
  end

  assign {sensorA, sensorB} = phase_code(state_q, dir_q);
  assign done               = (state_q == ST_P4) && (timer_value == '0);
  assign exp_count          = count_q;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a schedule-based reference model.
module tb_car_sensor_emulator;

  logic        clk;
  logic        res;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_dwell;
  logic        sensorA;
  logic        sensorB;
  logic        busy;
  logic        done;
  logic [13:0] exp_count;

  int n_pass  = 0;
  int n_total = 0;

  car_sensor_emulator #(
    .DWELL_W(8),
    .COUNT_W(14)
  ) dut (
    .clk      (clk),
    .res      (res),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_dwell(cmd_dwell),
    .sensorA  (sensorA),
    .sensorB  (sensorB),
    .busy     (busy),
    .done     (done),
    .exp_count(exp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: an accepted command becomes a schedule of 4*d cycles, indexed by k.
  logic        m_active = 1'b0;
  int          m_k = 0;
  int          m_d = 1;
  logic        m_dir = 1'b0;
  logic [13:0] m_count = '0;

  function automatic logic [1:0] model_code(input logic dir, input int phase);
    logic [1:0] c;
    case (phase)
      0:       c = dir ? 2'b10 : 2'b01;
      1:       c = 2'b11;
      2:       c = dir ? 2'b01 : 2'b10;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  initial begin
    logic [1:0]  e_code;
    logic        e_busy, e_done, e_ready;
    logic [18:0] e_vec, g_vec;
    forever begin
      @(posedge clk);
      if (res) begin
        m_active = 1'b0;
        m_count  = '0;
      end else if (m_active) begin
        m_k++;
        if (m_k == 3 * m_d) m_count = m_dir ? m_count + 14'd1 : m_count - 14'd1;
        if (m_k == 4 * m_d) m_active = 1'b0;
      end else if (cmd_valid) begin
        m_active = 1'b1;
        m_k      = 0;
        m_d      = (cmd_dwell == 8'd0) ? 1 : int'(cmd_dwell);
        m_dir    = cmd_dir;
      end
      #2;
      e_code  = m_active ? model_code(m_dir, m_k / m_d) : 2'b00;
      e_busy  = m_active;
      e_done  = m_active && (m_k == 4 * m_d - 1);
      e_ready = !m_active && !res;
      e_vec   = {e_code, e_busy, e_done, e_ready, m_count};
      g_vec   = {sensorA, sensorB, busy, done, cmd_ready, exp_count};
      check("cycle {AB,busy,done,ready,count}", 32'(g_vec), 32'(e_vec));
    end
  end

  // Returns one time unit after the accepting edge; cmd_valid is then left at hold.
  task automatic send(input logic dir, input logic [7:0] dwell, input logic hold);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_dwell = dwell;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = hold;
  endtask

  // Enter with dwell=2, optionally scrambling the command inputs mid-sequence.
  task automatic enter_dwell2(input logic scramble, input logic [13:0] count_after);
    logic [1:0] exp_seq [8];
    logic [1:0] got;
    exp_seq = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    send(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      got = {sensorA, sensorB};
      check($sformatf("enter2 code[%0d]", i), 32'(got), 32'(exp_seq[i]));
      if (i == 5) check("enter2 count before", 32'(exp_count), 32'(count_after - 14'd1));
      if (i == 6) check("enter2 count after", 32'(exp_count), 32'(count_after));
      check($sformatf("enter2 done[%0d]", i), 32'(done), (i == 7) ? 32'd1 : 32'd0);
      if (scramble && i == 2) begin
        cmd_dir   = ~cmd_dir;
        cmd_dwell = 8'd9;
      end
      @(posedge clk); #1;
    end
    #1;
    check("enter2 ready after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_exit [4];
    logic [1:0] got;
    res       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_dwell = 8'd0;

    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(posedge clk); #2;
    check("reset sensors", 32'({sensorA, sensorB}), 32'd0);
    check("reset count", 32'(exp_count), 32'd0);
    check("reset ready", 32'(cmd_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    enter_dwell2(1'b0, 14'd1);
    enter_dwell2(1'b1, 14'd2);

    // Reset while in P2 of a dwell=5 enter.
    send(1'b1, 8'd5, 1'b0);
    repeat (6) @(posedge clk);
    #1 res = 1'b1;
    @(posedge clk); #1 res = 1'b0;
    #1;
    check("midreset sensors", 32'({sensorA, sensorB}), 32'd0);
    check("midreset count", 32'(exp_count), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset ready", 32'(cmd_ready), 32'd1);

    // Exit with dwell=0 from zero wraps down; a following enter wraps back up.
    exp_exit = '{2'b01, 2'b11, 2'b10, 2'b00};
    send(1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      got = {sensorA, sensorB};
      check($sformatf("exit0 code[%0d]", i), 32'(got), 32'(exp_exit[i]));
      check($sformatf("exit0 done[%0d]", i), 32'(done), (i == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    check("exit0 count wrap", 32'(exp_count), 32'd16383);
    send(1'b1, 8'd1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("enter wrap to 0", 32'(exp_count), 32'd0);

    // Back-to-back enters with cmd_valid held: one idle cycle between sequences.
    send(1'b1, 8'd1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      #1;
      if (i == 4 || i == 9 || i == 14) check($sformatf("b2b idle busy[%0d]", i), 32'(busy), 32'd0);
      if (i == 13) check("b2b count", 32'(exp_count), 32'd3);
      if (i == 10) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Random traffic, including occasional resets.
    for (int c = 0; c < 1500; c++) begin
      res       = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_dwell = 8'($urandom_range(0, 4));
      @(posedge clk); #1;
    end
    res       = 1'b0;
    cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
